me_mb_scheduler: RTL and testbench

ME_MB_SCHEDULER -- requirements
Module: me_mb_scheduler

---
 rtl/me_mb_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_me_mb_scheduler.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/me_mb_scheduler.sv
// Macroblock scheduler for a full-search motion-estimation engine: walks the frame in
// raster order, launches one search per macroblock and keeps the minimum-SAD vector.
module me_mb_scheduler #(
    parameter int MB_COLS = 22,
    parameter int MB_ROWS = 18,
    parameter int RANGE   = 16,
    parameter int SAD_W   = 16,
    localparam int XW     = (MB_COLS > 1) ? $clog2(MB_COLS) : 1,
    localparam int YW     = (MB_ROWS > 1) ? $clog2(MB_ROWS) : 1,
    localparam int MVW    = $clog2(RANGE) + 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_start,
    output logic                  busy,
    output logic                  frame_done,
    input  logic                  me_ready,
    output logic                  me_start,
    input  logic                  sad_valid,
    input  logic [SAD_W-1:0]      sad,
    output logic [XW-1:0]         mb_x,
    output logic [YW-1:0]         mb_y,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic signed [MVW-1:0] mv_x,
    output logic signed [MVW-1:0] mv_y,
    output logic [SAD_W-1:0]      best_sad
);

    localparam int N  = 2 * RANGE + 1;
    localparam int CW = $clog2(N) + 1;

    localparam logic [CW-1:0]  POS_LAST = CW'(N - 1);
    localparam logic [MVW-1:0] MV_OFS   = MVW'(RANGE);
    localparam logic [XW-1:0]  COL_LAST = XW'(MB_COLS - 1);
    localparam logic [YW-1:0]  ROW_LAST = YW'(MB_ROWS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_SEARCH = 3'd2;
    localparam logic [2:0] S_RESULT = 3'd3;
    localparam logic [2:0] S_NEXT   = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CW-1:0]    col_q, col_d;
    logic [CW-1:0]    row_q, row_d;
    logic [SAD_W-1:0] best_q, best_d;
    logic [MVW-1:0]   mvx_q, mvx_d;
    logic [MVW-1:0]   mvy_q, mvy_d;
    logic [XW-1:0]    mbx_q, mbx_d;
    logic [YW-1:0]    mby_q, mby_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic col_even;
    logic row_end;
    logic take;

    // Even columns scan rows upward, odd columns downward.
    assign col_even = ~col_q[0];
    assign row_end  = col_even ? (row_q == POS_LAST) : (row_q == '0);
    // The very first candidate is forced in so an all-ones SAD still produces a vector.
    assign take     = ((col_q == '0) && (row_q == '0)) || (sad < best_q);

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        best_d   = best_q;
        mvx_d    = mvx_q;
        mvy_d    = mvy_q;
        mbx_d    = mbx_q;
        mby_d    = mby_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        me_start = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    state_d = S_LAUNCH;
                    mbx_d   = '0;
                    mby_d   = '0;
                    busy_d  = 1'b1;
                end
            end

            S_LAUNCH: begin
                if (me_ready) begin
                    me_start = 1'b1;
                    col_d    = '0;
                    row_d    = '0;
                    best_d   = '1;
                    state_d  = S_SEARCH;
                end
            end

            S_SEARCH: begin
                if (sad_valid) begin
                    if (take) begin
                        best_d = sad;
                        mvx_d  = MVW'(col_q) - MV_OFS;
                        mvy_d  = MVW'(row_q) - MV_OFS;
                    end
                    if (row_end) begin
                        if (col_q == POS_LAST) begin
                            state_d = S_RESULT;
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                    end else if (col_even) begin
                        row_d = row_q + CW'(1);
                    end else begin
                        row_d = row_q - CW'(1);
                    end
                end
            end

            S_RESULT: begin
                if (res_ready) begin
                    state_d = S_NEXT;
                end
            end

            S_NEXT: begin
                if (mbx_q == COL_LAST) begin
                    mbx_d = '0;
                    if (mby_q == ROW_LAST) begin
                        mby_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        mby_d   = mby_q + YW'(1);
                        state_d = S_LAUNCH;
                    end
                end else begin
                    mbx_d   = mbx_q + XW'(1);
                    state_d = S_LAUNCH;
                end
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            best_q  <= '0;
            mvx_q   <= '0;
            mvy_q   <= '0;
            mbx_q   <= '0;
            mby_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            best_q  <= best_d;
            mvx_q   <= mvx_d;
            mvy_q   <= mvy_d;
            mbx_q   <= mbx_d;
            mby_q   <= mby_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy       = busy_q;
    assign frame_done = done_q;
    assign res_valid  = (state_q == S_RESULT);
    assign mb_x       = mbx_q;
    assign mb_y       = mby_q;
    assign mv_x       = mvx_q;
    assign mv_y       = mvy_q;
    assign best_sad   = best_q;

endmodule

// File: tb/tb_me_mb_scheduler.sv
// Directed bench for me_mb_scheduler on a 2x2 frame with a +/-1 search range (9 candidates).
module tb_me_mb_scheduler;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              frame_start = 1'b0;
    logic              me_ready = 1'b0;
    logic              sad_valid = 1'b0;
    logic              res_ready = 1'b0;
    logic [15:0]       sad = '0;
    logic              busy, frame_done, me_start, res_valid;
    logic [0:0]        mb_x, mb_y;
    logic signed [1:0] mv_x, mv_y;
    logic [15:0]       best_sad;

    int total = 0;
    int bad = 0;
    int ms_cnt = 0;
    int fd_cnt = 0;
    int ms0, fd0, stable;
    logic [15:0] sads [9];

    me_mb_scheduler #(.MB_COLS(2), .MB_ROWS(2), .RANGE(1), .SAD_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .busy(busy),
        .frame_done(frame_done), .me_ready(me_ready), .me_start(me_start),
        .sad_valid(sad_valid), .sad(sad), .mb_x(mb_x), .mb_y(mb_y),
        .res_valid(res_valid), .res_ready(res_ready), .mv_x(mv_x), .mv_y(mv_y),
        .best_sad(best_sad)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (me_start === 1'b1) ms_cnt <= ms_cnt + 1;
        if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic wait_ms(input string tag);
        int n = 0;
        int seen = 0;
        while (seen == 0 && n < 50) begin
            @(negedge clk);
            if (me_start === 1'b1) seen = 1;
            n++;
        end
        chk(tag, seen, 1);
    endtask

    // Call right after wait_ms: the next edge moves LAUNCH -> SEARCH.
    task automatic feed();
        @(posedge clk); #1;
        for (int i = 0; i < 9; i++) begin
            sad_valid = 1'b1;
            sad = sads[i];
            @(posedge clk); #1;
        end
        sad_valid = 1'b0;
        sad = '0;
    endtask

    task automatic accept();
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic chk_res(input string tag, input int bs, input int mx, input int my);
        chk({tag, "_valid"}, int'(res_valid), 1);
        chk({tag, "_sad"}, int'(best_sad), bs);
        chk({tag, "_mvx"}, int'(mv_x), mx);
        chk({tag, "_mvy"}, int'(mv_y), my);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(frame_done), 0);
        chk("rst_resv", int'(res_valid), 0);
        chk("rst_sad", int'(best_sad), 0);
        chk("rst_mvx", int'(mv_x), 0);
        chk("rst_mbx", int'(mb_x), 0);
        me_ready = 1'b1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_no_ms", ms_cnt, 0);

        // Descending SADs: last candidate (col 2, row 2) wins.
        ms0 = ms_cnt;
        pulse_start();
        chk("busy_on", int'(busy), 1);
        wait_ms("ms_mb0");
        sads = '{16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
        feed();
        chk_res("desc", 1, 1, 1);
        chk("desc_ms_once", ms_cnt - ms0, 1);

        stable = 1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (!(res_valid === 1'b1 && best_sad == 16'd1 && mv_x == 2'sd1 && mv_y == 2'sd1))
                stable = 0;
        end
        chk("hold_stable", stable, 1);
        chk("hold_no_ms", ms_cnt - ms0, 1);

        accept();
        wait_ms("ms_mb1");
        chk("mb1_x", int'(mb_x), 1);
        chk("mb1_y", int'(mb_y), 0);
        sads = '{16'd5, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5};
        feed();
        chk_res("tie_all", 5, -1, -1);

        accept();
        wait_ms("ms_mb2");
        chk("mb2_x", int'(mb_x), 0);
        chk("mb2_y", int'(mb_y), 1);
        sads = '{16'd7, 16'd3, 16'd9, 16'd3, 16'd8, 16'd8, 16'd8, 16'd8, 16'd8};
        feed();
        chk_res("tie_early", 3, -1, 0);

        accept();
        wait_ms("ms_mb3");
        chk("mb3_x", int'(mb_x), 1);
        chk("mb3_y", int'(mb_y), 1);
        sads = '{16'd10, 16'd10, 16'd10, 16'd10, 16'd10, 16'd2, 16'd10, 16'd10, 16'd10};
        feed();
        chk_res("odd_col", 2, 0, -1);

        fd0 = fd_cnt;
        accept();
        chk("next_busy", int'(busy), 1);
        chk("next_done", int'(frame_done), 0);
        @(posedge clk); #1;
        chk("fd_pulse", int'(frame_done), 1);
        chk("fd_busy", int'(busy), 0);
        chk("fd_mbx", int'(mb_x), 0);
        chk("fd_mby", int'(mb_y), 0);
        @(posedge clk); #1;
        chk("fd_low", int'(frame_done), 0);
        chk("fd_count", fd_cnt - fd0, 1);

        // Reset in the middle of a search.
        pulse_start();
        wait_ms("ms_rst");
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            sad_valid = 1'b1;
            sad = 16'(i);
            @(posedge clk); #1;
        end
        sad_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_busy", int'(busy), 0);
        chk("mid_ms", int'(me_start), 0);
        chk("mid_resv", int'(res_valid), 0);
        chk("mid_sad", int'(best_sad), 0);
        chk("mid_mvx", int'(mv_x), 0);
        chk("mid_mvy", int'(mv_y), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ms0 = ms_cnt;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_no_ms", ms_cnt - ms0, 0);
        pulse_start();
        wait_ms("ms_rerun");
        sads = '{16'd4, 16'd4, 16'd1, 16'd4, 16'd4, 16'd4, 16'd4, 16'd4, 16'd4};
        feed();
        chk_res("rerun", 1, -1, 1);

        // Stray SADs in RESULT.
        sad_valid = 1'b1;
        sad = '0;
        repeat (3) @(posedge clk);
        #1;
        sad_valid = 1'b0;
        chk_res("stray_res", 1, -1, 1);

        // Engine not ready, stray res_ready and frame_start while busy.
        me_ready = 1'b0;
        ms0 = ms_cnt;
        accept();
        res_ready = 1'b1;
        frame_start = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        res_ready = 1'b0;
        frame_start = 1'b0;
        chk("nrdy_no_ms", ms_cnt - ms0, 0);
        chk("nrdy_mbx", int'(mb_x), 1);
        chk("nrdy_busy", int'(busy), 1);
        me_ready = 1'b1;
        wait_ms("ms_rdy");
        chk("rdy_mbx", int'(mb_x), 1);
        chk("rdy_mby", int'(mb_y), 0);
        sads = '{16'd6, 16'd6, 16'd6, 16'd6, 16'd6, 16'd6, 16'd6, 16'd2, 16'd6};
        feed();
        chk_res("rdy", 2, 1, 0);

        // Stray inputs in IDLE.
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        ms0 = ms_cnt;
        sad_valid = 1'b1;
        res_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        sad_valid = 1'b0;
        res_ready = 1'b0;
        chk("idle_no_ms", ms_cnt - ms0, 0);
        chk("idle_resv", int'(res_valid), 0);
        chk("idle_busy", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
